// File: rtl/pipeline_types.sv
// Shared types for the data-cache arbiter: request record, FSM state encoding
// and the default requester count.
package pipeline_types;

  localparam int ISSUE_WIDTH = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dcache_req_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } arb_state_t;

endpackage

// File: rtl/dcache_arbiter_if.sv
// Arbiter-to-dcache bus: one request channel with address and data handshakes.
interface dcache_arbiter_if;

  logic                      cache_valid;
  pipeline_types::dcache_req_t cache_req;
  logic                      cache_addr_ok;
  logic                      cache_data_ok;
  logic [31:0]               cache_rdata;

  modport master (
    output cache_valid,
    output cache_req,
    input  cache_addr_ok,
    input  cache_data_ok,
    input  cache_rdata
  );

  modport slave (
    input  cache_valid,
    input  cache_req,
    output cache_addr_ok,
    output cache_data_ok,
    output cache_rdata
  );

endinterface

// File: rtl/dcache_arb_perf.sv
// Free-running wrap-around counters for accepted dcache requests and arbiter stall cycles.
module dcache_arb_perf #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] req_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [PERF_W-1:0] req_cnt_q, req_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    req_cnt_d   = req_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (req_inc)   req_cnt_d   = req_cnt_q + PERF_W'(1);
    if (stall_inc) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign req_cnt   = req_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/dcache_arbiter.sv
// Serialises a batch of per-lane memory accesses onto a single dcache port, oldest lane first.
// Define DCACHE_ARB_PERF_EN to add the perf_req_cnt / perf_stall_cnt counters.
module dcache_arbiter
  import pipeline_types::*;
#(
  parameter int NUM_REQ = ISSUE_WIDTH,
  parameter int PERF_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  dcache_req_t [NUM_REQ-1:0]    req,
  dcache_arbiter_if.master             cache,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [NUM_REQ-1:0][31:0]     resp_rdata,
  output logic                         pause_arb
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_req_cnt,
  output logic [PERF_W-1:0]            perf_stall_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (PERF_W < 1) begin : g_perf_w_chk
    $error("dcache_arbiter: PERF_W must be at least 1");
  end

  arb_state_t                   state_q, state_d;
  logic [NUM_REQ-1:0]           pending_q, pending_d;
  logic [NUM_REQ-1:0]           mask_q, mask_d;
  logic [IDX_W-1:0]             cur_q, cur_d;
  logic                         abort_q, abort_d;
  dcache_req_t [NUM_REQ-1:0]    buf_q, buf_d;
  logic [NUM_REQ-1:0][31:0]     rdata_q, rdata_d;

  logic                         cache_valid_o;
  dcache_req_t                  cache_req_o;
  logic                         complete;
  logic [NUM_REQ-1:0]           remaining;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REQ-1:0] m);
    lowest = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (m[i]) lowest = IDX_W'(i);
    end
  endfunction

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mask_d        = mask_q;
    cur_d         = cur_q;
    abort_d       = abort_q;
    buf_d         = buf_q;
    rdata_d       = rdata_q;
    cache_valid_o = 1'b0;
    cache_req_o   = buf_q[cur_q];
    resp_valid    = '0;
    pause_arb     = 1'b0;
    complete      = 1'b0;
    remaining     = pending_q & ~(NUM_REQ'(1) << cur_q);

    unique case (state_q)
      IDLE: begin
        if (|req_valid && !flush) begin
          pause_arb = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) buf_d[i] = req[i];
          end
          pending_d = req_valid;
          mask_d    = req_valid;
          cur_d     = lowest(req_valid);
          abort_d   = 1'b0;
          state_d   = ISSUE;
        end
      end

      // The request must stay on the bus until accepted, even for a flushed batch.
      ISSUE: begin
        cache_valid_o = 1'b1;
        pause_arb     = 1'b1;
        if (flush) begin
          pending_d = '0;
          abort_d   = 1'b1;
        end
        if (cache.cache_addr_ok) begin
          if (flush || abort_q) begin
            state_d = cache.cache_data_ok ? IDLE : DRAIN;
          end else if (cache.cache_data_ok) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        pause_arb = 1'b1;
        if (flush) begin
          pending_d = '0;
          state_d   = cache.cache_data_ok ? IDLE : DRAIN;
        end else if (cache.cache_data_ok) begin
          complete = 1'b1;
        end
      end

      DONE: begin
        if (!flush) resp_valid = mask_q;
        state_d = IDLE;
      end

      DRAIN: begin
        pause_arb = 1'b1;
        if (cache.cache_data_ok) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion of the in-flight lane: capture its result and move to the next pending lane.
    if (complete) begin
      rdata_d[cur_q] = buf_q[cur_q].we ? 32'h0 : cache.cache_rdata;
      pending_d      = remaining;
      if (|remaining) begin
        cur_d   = lowest(remaining);
        state_d = ISSUE;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      cur_q     <= '0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cur_q     <= cur_d;
      abort_q   <= abort_d;
      rdata_q   <= rdata_d;
    end
  end

  // Request buffers only carry payload; their content is qualified by pending_q.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign cache.cache_valid = cache_valid_o;
  assign cache.cache_req   = cache_req_o;
  assign resp_rdata        = rdata_q;

`ifdef DCACHE_ARB_PERF_EN
  dcache_arb_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .req_inc   (cache_valid_o & cache.cache_addr_ok),
    .stall_inc (pause_arb),
    .req_cnt   (perf_req_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: doc/dcache_arbiter.md
DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_REQ, 2, requester lanes; lane 0 is oldest in program order.
- PERF_W, 32, performance counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; abort the current batch.
- req_valid  in  NUM_REQ  lane has a memory access this cycle.
- req  in  NUM_REQ x dcache_req_t  per lane {we, addr[31:0], wdata[31:0], wstrb[3:0]}.
- cache_valid  out  1  request to dcache.
- cache_req  out  dcache_req_t  selected lane fields.
- cache_addr_ok  in  1  dcache accepted the request.
- cache_data_ok  in  1  dcache returned read data or write ack.
- cache_rdata  in  32  raw read word.
- resp_valid  out  NUM_REQ  one-cycle pulse: lane result ready.
- resp_rdata  out  NUM_REQ x 32  raw word per lane; byte/half extraction stays in the mem stage.
- pause_arb  out  1  stall request to ctrl.
- perf_req_cnt, perf_stall_cnt  out  PERF_W each  present only with the macro (REQ-015).

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE and DRAIN.

REQ-004 Latching in IDLE:
- Condition: |req_valid & !flush.
- Action: latch every valid lane's req into a per-lane buffer, set pending mask = req_valid, go to ISSUE next cycle.
- Latching SHALL NOT occur in any other state.

REQ-005 ISSUE state:
- cache_valid=1; cache_req = buffer of the lowest-index pending lane.
- Both SHALL be held stable until cache_addr_ok.
- On addr_ok, go to WAIT.
- addr_ok and data_ok in the same cycle SHALL count as completion (skip WAIT).

REQ-006 WAIT state:
- cache_valid=0.
- On cache_data_ok: store cache_rdata into that lane's result register (stores write 0), clear its pending bit.
- Then go to ISSUE if pending bits remain, else to DONE.

REQ-007 DONE state:
- Lasts exactly one cycle.
- resp_valid = latched original mask.
- pause_arb=0, so the mem stage advances.
- Then go to IDLE.
- resp_rdata SHALL hold until the next batch latch.

REQ-008 pause_arb SHALL be 1 in IDLE when |req_valid & !flush, and in ISSUE, WAIT and DRAIN; it SHALL be 0 otherwise.

REQ-009 Minimum latency: one lane with addr_ok and data_ok both next-cycle completes in 4 cycles (IDLE latch → ISSUE → WAIT → DONE). Two lanes SHALL be serviced strictly serially, lane 0 first.

REQ-010 Flush handling:
- Flush in IDLE or DONE: no latch, go to IDLE.
- Flush in ISSUE: keep cache_valid held until addr_ok, then go to DRAIN; if data_ok arrives in the same cycle, go to IDLE.
- Flush in WAIT: go to DRAIN, or to IDLE if data_ok arrives in that cycle.
- DRAIN: wait for data_ok, discard data, go to IDLE.
- Flush SHALL clear all pending bits; no resp_valid SHALL be produced for a flushed batch.

REQ-011 Only one dcache transaction SHALL be outstanding at any time.

REQ-012 Requesters SHALL deassert req_valid for excepting instructions; the arbiter performs no exception checks.

Reset
REQ-013 On rst, all of the following SHALL clear on the next edge and take priority over all inputs: state=IDLE, pending=0, cache_valid=0, resp_valid=0, resp_rdata=0, perf counters=0.

REQ-014 Reset mid-transaction SHALL abandon the outstanding access; the dcache is reset by the same rst, so no stale data_ok is expected.

Configuration
REQ-015 Macro DCACHE_ARB_PERF_EN:
- Defined: perf_req_cnt increments once per cache_addr_ok; perf_stall_cnt increments every cycle pause_arb=1. Both wrap modulo 2^PERF_W.
- Undefined: ports and counter logic are absent; all other behaviour is unchanged.

Structure
REQ-016 pipeline_types SHALL hold dcache_req_t, arb_state_t (enum) and NUM_REQ's default via ISSUE_WIDTH.

REQ-017 Counters SHALL live in sub-module dcache_arb_perf, instantiated only under DCACHE_ARB_PERF_EN.

Verification
REQ-018 Single load, lane 0:
- Stimulus: addr 0x1000; addr_ok after 1 cycle; data_ok 2 cycles later with rdata 0xDEADBEEF.
- Response: one cache_valid transaction; resp_valid=2'b01, resp_rdata[0]=0xDEADBEEF in DONE; pause_arb low only in DONE.

REQ-019 Dual lane:
- Stimulus: lane 0 load 0x2000, lane 1 store 0x2004 wdata 0x55 wstrb 4'hF.
- Response: lane 0 issued first; lane 1 cache_valid only after lane 0 data_ok; resp_valid=2'b11 exactly once.

REQ-020 Backpressure:
- Stimulus: cache_addr_ok held low 5 cycles.
- Response: cache_valid/cache_req stable for all 5 cycles; pause_arb=1 throughout.

REQ-021 Flush in WAIT:
- Stimulus: two-lane batch, flush while lane 0 is outstanding.
- Response: DRAIN until data_ok; lane 1 never issued; resp_valid never asserted; IDLE afterwards.

REQ-022 Reset in ISSUE:
- Stimulus: rst=1 one cycle.
- Response: cache_valid=0 and pause_arb=0 next cycle; with DCACHE_ARB_PERF_EN, both counters read 0.

REQ-023 Counter wrap:
- Stimulus: PERF_W=4, 17 transactions.
- Response: perf_req_cnt=1.
